// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin sharing of one combinational signed multiplier between
// NUM_REQ requesters. Operands are registered towards the multiplier and the
// product is piped back, tagged with the issuing requester, as a one-hot
// single-cycle response strobe.
//
// Build option: define MULT_SHARE_STATS_EN to get the saturating
// grant_count / conflict_count statistics counters. Without it both ports
// are tied to zero and no counter logic exists.
//
// Parameter ranges: NUM_REQ 2..8, PIPE_STAGES 1..4.

module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 9,
    parameter int PIPE_STAGES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           mult_a,
    output logic [WIDTH-1:0]           mult_b,
    input  logic [2*WIDTH-1:0]         mult_result,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]         resp_data,
    output logic                       busy,
    output logic [15:0]                grant_count,
    output logic [15:0]                conflict_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PW    = 2 * WIDTH;
    localparam int LAST  = PIPE_STAGES - 1;

    // Round-robin pointer: the requester that has highest priority this cycle.
    logic [IDX_W-1:0] rrPtr_q, rrPtr_d;

    // Arbitration results for the current cycle.
    logic             grantAny;
    logic [IDX_W-1:0] winnerIdx;
    logic             hiFound;
    logic [IDX_W-1:0] hiIdx;
    logic             loFound;
    logic [IDX_W-1:0] loIdx;

    // Issue stage: operands driven to the multiplier plus the tag of the
    // operation they belong to.
    logic [WIDTH-1:0] multA_q, multA_d;
    logic [WIDTH-1:0] multB_q, multB_d;
    logic             issueValid_q, issueValid_d;
    logic [IDX_W-1:0] issueTag_q, issueTag_d;

    // Result pipeline: stage 0 captures the multiplier output, the last
    // stage drives the response ports.
    logic [PIPE_STAGES-1:0] pipeValid_q, pipeValid_d;
    logic [IDX_W-1:0]       pipeTag_q  [PIPE_STAGES];
    logic [IDX_W-1:0]       pipeTag_d  [PIPE_STAGES];
    logic [PW-1:0]          pipeData_q [PIPE_STAGES];
    logic [PW-1:0]          pipeData_d [PIPE_STAGES];

    // Find the first valid requester at or above rrPtr, otherwise wrap
    // around to the lowest valid one; flush suppresses any grant.
    always_comb begin
        hiFound   = 1'b0;
        hiIdx     = '0;
        loFound   = 1'b0;
        loIdx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                loFound = 1'b1;
                loIdx   = IDX_W'(i);
                if (IDX_W'(i) >= rrPtr_q) begin
                    hiFound = 1'b1;
                    hiIdx   = IDX_W'(i);
                end
            end
        end
        winnerIdx = hiFound ? hiIdx : loIdx;
        grantAny  = loFound && !flush;
    end

    // One-hot ready towards the winning requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grantAny && (winnerIdx == IDX_W'(i));
        end
    end

    // Advance the pointer past the winner so it gets lowest priority next.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (grantAny) begin
            if (winnerIdx == IDX_W'(NUM_REQ - 1)) begin
                rrPtr_d = '0;
            end else begin
                rrPtr_d = winnerIdx + IDX_W'(1);
            end
        end
    end

    // Select the winner's operands; hold them when nothing is granted so the
    // multiplier inputs do not toggle needlessly.
    always_comb begin
        multA_d      = multA_q;
        multB_d      = multB_q;
        issueValid_d = grantAny;
        issueTag_d   = issueTag_q;
        if (grantAny) begin
            issueTag_d = winnerIdx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (winnerIdx == IDX_W'(i)) begin
                    multA_d = req_a[i*WIDTH +: WIDTH];
                    multB_d = req_b[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Shift the tagged product down the result pipeline; flush kills every
    // valid bit while leaving data in place.
    always_comb begin
        pipeValid_d    = '0;
        pipeValid_d[0] = issueValid_q && !flush;
        pipeTag_d[0]   = issueTag_q;
        pipeData_d[0]  = issueValid_q ? mult_result : pipeData_q[0];
        for (int k = 1; k < PIPE_STAGES; k++) begin
            pipeValid_d[k] = pipeValid_q[k-1] && !flush;
            pipeTag_d[k]   = pipeTag_q[k-1];
            pipeData_d[k]  = pipeValid_q[k-1] ? pipeData_q[k-1] : pipeData_q[k];
        end
    end

    // Arbitration and issue state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q      <= '0;
            multA_q      <= '0;
            multB_q      <= '0;
            issueValid_q <= 1'b0;
            issueTag_q   <= '0;
        end else begin
            rrPtr_q      <= rrPtr_d;
            multA_q      <= multA_d;
            multB_q      <= multB_d;
            issueValid_q <= issueValid_d;
            issueTag_q   <= issueTag_d;
        end
    end

    // Result pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeValid_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                pipeTag_q[k]  <= '0;
                pipeData_q[k] <= '0;
            end
        end else begin
            pipeValid_q <= pipeValid_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                pipeTag_q[k]  <= pipeTag_d[k];
                pipeData_q[k] <= pipeData_d[k];
            end
        end
    end

    // Decode the output-stage tag into the one-hot strobe; data is forced to
    // zero whenever no strobe is active.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (pipeValid_q[LAST]) begin
            resp_data = pipeData_q[LAST];
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_valid[i] = (pipeTag_q[LAST] == IDX_W'(i));
            end
        end
    end

    assign mult_a = multA_q;
    assign mult_b = multB_q;
    assign busy   = issueValid_q || (|pipeValid_q);

`ifdef MULT_SHARE_STATS_EN
    logic [15:0] grantCnt_q, grantCnt_d;
    logic [15:0] conflictCnt_q, conflictCnt_d;

    // Saturating statistics: accepted transfers and contended cycles.
    always_comb begin
        grantCnt_d    = grantCnt_q;
        conflictCnt_d = conflictCnt_q;
        if (grantAny && (grantCnt_q != 16'hFFFF)) begin
            grantCnt_d = grantCnt_q + 16'd1;
        end
        if (($countones(req_valid) > 1) && (conflictCnt_q != 16'hFFFF)) begin
            conflictCnt_d = conflictCnt_q + 16'd1;
        end
    end

    // Counters are cleared by reset only; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grantCnt_q    <= '0;
            conflictCnt_q <= '0;
        end else begin
            grantCnt_q    <= grantCnt_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign grant_count    = grantCnt_q;
    assign conflict_count = conflictCnt_q;
`else
    assign grant_count    = '0;
    assign conflict_count = '0;
`endif

endmodule
